// File: rtl/regfile_ctrl_fsm.sv
// Multi-cycle register-file controller for the Simple RISC Machine: one decoded
// instruction per s/w handshake. Optional macro REGFILE_CTRL_TRAP_EN adds the TRAP state and err port.
module regfile_ctrl_fsm #(
   parameter int RIDX_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s,
   input  logic [2:0]        opcode,
   input  logic [1:0]        op,
   input  logic [RIDX_W-1:0] rn,
   input  logic [RIDX_W-1:0] rd,
   input  logic [RIDX_W-1:0] rm,
   output logic              w,
   output logic [RIDX_W-1:0] writenum,
   output logic              write,
   output logic [RIDX_W-1:0] anum,
   output logic [RIDX_W-1:0] bnum,
   output logic              loada,
   output logic              loadb,
   output logic              loadc,
   output logic              loads,
   output logic              asel,
   output logic              bsel,
   output logic [1:0]        vsel,
`ifdef REGFILE_CTRL_TRAP_EN
   output logic              err,
`endif
   output logic [1:0]        aluop
);

   localparam logic [3:0] S_WAIT      = 4'd0;
   localparam logic [3:0] S_DECODE    = 4'd1;
   localparam logic [3:0] S_WRITE_IMM = 4'd2;
   localparam logic [3:0] S_GET_A     = 4'd3;
   localparam logic [3:0] S_GET_B     = 4'd4;
   localparam logic [3:0] S_ALU       = 4'd5;
   localparam logic [3:0] S_CMP       = 4'd6;
   localparam logic [3:0] S_WRITE_REG = 4'd7;
`ifdef REGFILE_CTRL_TRAP_EN
   localparam logic [3:0] S_TRAP      = 4'd8;
`endif

   logic [3:0]        state_q, state_d;
   logic [2:0]        opcode_q, opcode_d;
   logic [1:0]        op_q, op_d;
   logic [RIDX_W-1:0] rn_q, rn_d;
   logic [RIDX_W-1:0] rd_q, rd_d;
   logic [RIDX_W-1:0] rm_q, rm_d;

   logic alu_class, is_mov_reg, is_mvn, is_cmp, aluop_hold;

   assign alu_class  = (opcode_q == 3'b101);
   assign is_mov_reg = (opcode_q == 3'b110) && (op_q == 2'b00);
   assign is_mvn     = alu_class && (op_q == 2'b11);
   assign is_cmp     = alu_class && (op_q == 2'b01);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_WAIT;
         opcode_q <= '0;
         op_q     <= '0;
         rn_q     <= '0;
         rd_q     <= '0;
         rm_q     <= '0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         op_q     <= op_d;
         rn_q     <= rn_d;
         rd_q     <= rd_d;
         rm_q     <= rm_d;
      end
   end

   // Instruction fields are captured only on the accept edge and held until the next one.
   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      op_d     = op_q;
      rn_d     = rn_q;
      rd_d     = rd_q;
      rm_d     = rm_q;
      case (state_q)
         S_WAIT: begin
            if (s) begin
               state_d  = S_DECODE;
               opcode_d = opcode;
               op_d     = op;
               rn_d     = rn;
               rd_d     = rd;
               rm_d     = rm;
            end
         end
         S_DECODE: begin
            case ({opcode_q, op_q})
               5'b110_10:                       state_d = S_WRITE_IMM;
               5'b110_00, 5'b101_11:            state_d = S_GET_B;
               5'b101_00, 5'b101_01, 5'b101_10: state_d = S_GET_A;
`ifdef REGFILE_CTRL_TRAP_EN
               default:                         state_d = S_TRAP;
`else
               default:                         state_d = S_WAIT;
`endif
            endcase
         end
         S_GET_A:     state_d = S_GET_B;
         S_GET_B:     state_d = is_cmp ? S_CMP : S_ALU;
         S_ALU:       state_d = S_WRITE_REG;
         S_CMP:       state_d = S_WAIT;
         S_WRITE_REG: state_d = S_WAIT;
         S_WRITE_IMM: state_d = S_WAIT;
`ifdef REGFILE_CTRL_TRAP_EN
         S_TRAP:      state_d = S_TRAP;
`endif
         default:     state_d = S_WAIT;
      endcase
   end

`ifdef REGFILE_CTRL_TRAP_EN
   assign aluop_hold = (state_q != S_WAIT) && (state_q != S_TRAP);
   assign err        = (state_q == S_TRAP);
`else
   assign aluop_hold = (state_q != S_WAIT);
`endif

   always_comb begin
      w        = 1'b0;
      writenum = '0;
      write    = 1'b0;
      anum     = '0;
      bnum     = '0;
      loada    = 1'b0;
      loadb    = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      vsel     = 2'b00;
      aluop    = (aluop_hold && alu_class) ? op_q : 2'b00;
      case (state_q)
         S_WAIT:  w = 1'b1;
         S_GET_A: begin
            anum  = rn_q;
            loada = 1'b1;
         end
         S_GET_B: begin
            bnum  = rm_q;
            loadb = 1'b1;
         end
         S_ALU: begin
            loadc = 1'b1;
            asel  = is_mov_reg || is_mvn;
         end
         S_CMP:   loads = 1'b1;
         S_WRITE_REG: begin
            write    = 1'b1;
            writenum = rd_q;
         end
         S_WRITE_IMM: begin
            write    = 1'b1;
            writenum = rn_q;
            vsel     = 2'b10;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/regfile_ctrl_fsm.md
Name: regfile_ctrl_fsm

Overview:
- Multi-cycle controller that drives the CPU register file.
- Generates writenum/write/anum/bnum plus the datapath load and select strobes: loada/loadb/loadc/loads, asel/bsel/vsel, aluop.
- Executes one decoded Simple RISC Machine instruction per start/done (s/w) handshake.
- Sits between the instruction decoder and the datapath/register file.

Parameters:
RIDX_W, 3, register-index width; fixed at 3 for the 8-entry register file.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
s  input  1  start request; sampled only in WAIT
opcode  input  3  instruction opcode (110 = MOV class, 101 = ALU class)
op  input  2  sub-op
rn  input  RIDX_W  Rn field
rd  input  RIDX_W  Rd field
rm  input  RIDX_W  Rm field
w  output  1  idle/ready (1 only in WAIT)
writenum  output  RIDX_W  register-file write index
write  output  1  register-file write enable
anum  output  RIDX_W  register-file A read index
bnum  output  RIDX_W  register-file B read index
loada  output  1  load A pipeline register
loadb  output  1  load B pipeline register
loadc  output  1  load C (ALU result) register
loads  output  1  load status flags
asel  output  1  1 = force ALU A input to 0
bsel  output  1  1 = select sximm5 for B (always 0 in this block)
vsel  output  2  write-back source: 00 = C, 10 = sximm8
aluop  output  2  ALU operation

Behaviour:
- States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, CMP, WRITE_REG. Registered state with Moore outputs.
- Reset (synchronous) forces state WAIT and clears the latched fields.
  - Reset values: w=1; all other outputs 0.
  - Reset mid-instruction aborts with no register write.
- Accept: a rising edge with state WAIT and s=1 latches opcode/op/rn/rd/rm and moves to DECODE. Latched fields are stable until the next accept.
- Input changes after accept have no effect. s outside WAIT is ignored.
- DECODE, by latched opcode/op:
  - 110/10 -> WRITE_IMM
  - 110/00 -> GET_B
  - 101/11 -> GET_B
  - 101/00, 101/01, 101/10 -> GET_A
  - anything else: illegal (see Optional Feature)
- GET_A: anum=rn, loada=1 -> GET_B.
- GET_B: bnum=rm, loadb=1 -> CMP if 101/01, else ALU.
- ALU: loadc=1; asel=1 for MOV-reg and MVN, else 0; bsel=0 -> WRITE_REG.
- CMP: loads=1; asel=0 -> WAIT (no register write).
- WRITE_REG: write=1, writenum=rd, vsel=00 -> WAIT.
- WRITE_IMM: write=1, writenum=rn, vsel=10 -> WAIT.
- aluop = latched op for the 101 class and 00 for the 110 class, held from DECODE until the return to WAIT; 00 in WAIT.
- Index outputs (anum, bnum, writenum) are 0 in every state where they are not listed above.
- vsel, asel and bsel are 0 in every state where they are not listed above.
- Exactly one of write/loada/loadb/loadc/loads is high per cycle, or none.
- Cycles from accept edge to w=1:
  - MOV imm: 3
  - MOV reg, MVN: 5
  - CMP: 5
  - ADD, AND: 6
- Back-to-back: if s=1 on the cycle w returns to 1, the next instruction is accepted on that edge, so w is high for exactly one cycle.

Optional Feature:
Macro REGFILE_CTRL_TRAP_EN.
- Defined: an illegal opcode/op in DECODE moves to TRAP. In TRAP:
  - output err (1 bit, extra port) = 1, w=0, all strobes 0.
  - Only reset leaves TRAP.
- Undefined: illegal encodings return from DECODE to WAIT as a NOP. No strobes fire; w=1 two cycles after accept. No err port.

Test Plan:
- Reset, then s=1 with opcode=110, op=10, rn=3 -> write=1 with writenum=3 and vsel=10 for exactly one cycle; w=1 three cycles after the accept edge.
- ADD (101/00) with rn=1, rm=2, rd=5:
  - sequence loada (anum=1), loadb (bnum=2), loadc (asel=0, aluop=00), write (writenum=5, vsel=00);
  - w=1 six cycles after the accept edge.
- CMP (101/01) with rn=4, rm=6 -> loada, loadb, then loads=1 with aluop=01; write never asserted; w=1 after 5 cycles.
- MVN (101/11) with rm=7, rd=0 followed by s held high for a MOV imm -> ALU state has asel=1 and aluop=11; w is high for one cycle only and the MOV imm is accepted on that edge.
- Assert reset during GET_B of an ADD -> the next cycle has w=1, write=0 and all strobes 0, and no write occurs afterwards.
- opcode=111 -> with REGFILE_CTRL_TRAP_EN: err=1 and w=0 until reset. Without it: no strobes and w=1 two cycles after accept.
